// File: rtl/multimode_led_counter_pkg.sv
// Shared encodings for the multimode LED counter: the MODE input values
// and the bounce direction flag.
package multimode_led_counter_pkg;

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_GRAY   = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/multimode_led_counter_tick_prescaler.sv
// tick_prescaler: divides CLK down to a one-cycle STEP strobe every
// TICK_LIMIT enabled clocks. EN=0 holds the count. CLR restarts the period
// from zero. BTN is an asynchronous active-high reset.
module tick_prescaler #(
    parameter int TICK_LIMIT = 12_000_000
) (
    input  logic CLK,
    input  logic BTN,
    input  logic EN,
    input  logic CLR,
    output logic STEP
);

    localparam int CW = (TICK_LIMIT > 1) ? $clog2(TICK_LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_LIMIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_last;

    assign at_last = (cnt_q == LAST);

    // STEP is taken from the current count, so it coincides with the edge
    // on which the prescaler wraps back to zero.
    assign STEP = EN && at_last;

    // Next prescaler value: clear has priority, otherwise advance and wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (CLR) begin
            cnt_d = '0;
        end else if (EN) begin
            cnt_d = at_last ? '0 : cnt_q + CW'(1);
        end
    end

    // Prescaler register with asynchronous reset.
    always_ff @(posedge CLK or posedge BTN) begin
        if (BTN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multimode_led_counter.sv
// multimode_led_counter: WIDTH-bit LED counter that steps once every
// TICK_LIMIT clocks in binary up, binary down, Gray up or bounce mode, with
// enable, synchronous load and TICK/WRAP strobes.
// Optional PWM dimming is compiled in when MULTIMODE_LED_COUNTER_PWM_DIM_EN
// is defined; this adds the 4-bit DIM input.
module multimode_led_counter
    import multimode_led_counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int TICK_LIMIT = 12_000_000
) (
    input  logic             CLK,
    input  logic             BTN,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
`ifdef MULTIMODE_LED_COUNTER_PWM_DIM_EN
    input  logic [3:0]       DIM,
`endif
    output logic [WIDTH-1:0] LED_OUT,
    output logic             TICK,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic             step;
    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] pattern_d;
    logic             pwm_on;

    // A load restarts the step period, so the first step after it lands
    // TICK_LIMIT enabled clocks later.
    tick_prescaler #(
        .TICK_LIMIT(TICK_LIMIT)
    ) u_prescaler (
        .CLK (CLK),
        .BTN (BTN),
        .EN  (EN),
        .CLR (LOAD),
        .STEP(step)
    );

`ifdef MULTIMODE_LED_COUNTER_PWM_DIM_EN
    logic [3:0] pwm_q, pwm_d;

    assign pwm_d  = pwm_q + 4'd1;
    assign pwm_on = (pwm_q < DIM);

    // Free-running PWM phase counter; DIM sets how many of the 16 phases are lit.
    always_ff @(posedge CLK or posedge BTN) begin
        if (BTN) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end
`else
    assign pwm_on = 1'b1;
`endif

    // Next count, direction and strobes. A load wins over a coincident step,
    // and the direction is held at UP whenever bounce mode is not selected.
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (LOAD) begin
            count_d = LOAD_VAL;
            dir_d   = (LOAD_VAL == CNT_MAX) ? DIR_DOWN : DIR_UP;
        end else if (step) begin
            tick_d = 1'b1;
            case (MODE)
                MODE_UP, MODE_GRAY: begin
                    count_d = count_q + ONE;
                    wrap_d  = (count_q == CNT_MAX);
                end
                MODE_DOWN: begin
                    count_d = count_q - ONE;
                    wrap_d  = (count_q == '0);
                end
                default: begin
                    if (dir_q == DIR_UP) begin
                        if (count_q == CNT_MAX) begin
                            count_d = count_q - ONE;
                            dir_d   = DIR_DOWN;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = count_q + ONE;
                        end
                    end else begin
                        if (count_q == '0) begin
                            count_d = ONE;
                            dir_d   = DIR_UP;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = count_q - ONE;
                        end
                    end
                end
            endcase
        end
        if (MODE != MODE_BOUNCE) begin
            dir_d = DIR_UP;
        end
    end

    // LED pattern is encoded from the next count every cycle, so a mode
    // change alone re-encodes the display on the following edge.
    always_comb begin
        pattern_d = (MODE == MODE_GRAY) ? (count_d ^ (count_d >> 1)) : count_d;
        led_d     = pattern_d & {WIDTH{pwm_on}};
    end

    // Counter state and registered outputs with asynchronous reset.
    always_ff @(posedge CLK or posedge BTN) begin
        if (BTN) begin
            count_q <= '0;
            dir_q   <= DIR_UP;
            led_q   <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            led_q   <= led_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign LED_OUT = led_q;
    assign TICK    = tick_q;
    assign WRAP    = wrap_q;

endmodule
